// File: rtl/decode_inst_queue.sv
// Instruction queue between Fetch and Decode. A circular buffer of {pc, inst, meta}
// records with valid/ready on both sides, branch-redirect delay-slot retention and flush.
module decode_inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned META_W = 3,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              redirect,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [META_W-1:0] out_meta,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [META_W-1:0] meta;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  entry_t             head_q, head_d;
  logic               push, pop;

  // Next-state: flush beats redirect beats normal push/pop accounting.
  always_comb begin
    push     = in_valid & in_ready_q;
    pop      = out_valid_q & out_ready;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else if (redirect && pop && (count_q >= CNT_W'(2))) begin
      // Keep only the delay slot behind the branch; the offered push is dropped.
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_ptr_d = rd_ptr_q + PTR_W'(2);
      count_d  = CNT_W'(1);
    end else begin
      // A redirect with one entry falls through here: the push (if any) is the delay slot.
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: in_pc, inst: in_inst, meta: in_meta};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != '0);
    head_d      = out_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
    end
  end

  // Storage array; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = head_q.pc;
  assign out_inst  = head_q.inst;
  assign out_meta  = head_q.meta;
  assign count     = count_q;

endmodule

// File: tb/tb_decode_inst_queue.sv
// Directed bench for decode_inst_queue: a vector table plus a short hand-written sequence.
module tb_decode_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, redirect, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;
  logic [2:0]  in_meta;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  out_meta;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_inst_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .redirect(redirect),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_meta(in_meta), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_meta(out_meta), .count(count)
  );

  typedef struct {
    logic        rst, flush, redirect, iv, ord;
    logic [31:0] pc;
    logic        e_valid, e_ready;
    logic [2:0]  e_count;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return ~pc;
  endfunction

  function automatic logic [2:0] meta_of(input logic [31:0] pc);
    return pc[4:2];
  endfunction

  task automatic add(input logic r, input logic f, input logic rd, input logic iv,
                     input logic [31:0] pc, input logic ord, input logic ev,
                     input logic er, input logic [2:0] ec, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.flush = f; v.redirect = rd; v.iv = iv; v.pc = pc; v.ord = ord;
    v.e_valid = ev; v.e_ready = er; v.e_count = ec; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic rd, input logic iv,
                       input logic [31:0] pc, input logic ord);
    rst = r; flush = f; redirect = rd; in_valid = iv; out_ready = ord;
    in_pc = pc; in_inst = inst_of(pc); in_meta = meta_of(pc);
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic er,
                               input logic [2:0] ec, input logic [31:0] epc);
    string tag;
    tag = $sformatf("row%0d", idx);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(er));
    chk({tag, ".count"},     32'(count),     32'(ec));
    chk({tag, ".out_pc"},    out_pc,         epc);
    chk({tag, ".out_inst"},  out_inst,       ev ? inst_of(epc) : 32'h0);
    chk({tag, ".out_meta"},  32'(out_meta),  ev ? 32'(meta_of(epc)) : 32'h0);
  endtask

  initial begin
    int k;
    logic [31:0] wrap_head [2];
    logic        seen;

    // rst flush redir iv pc ord | valid ready count pc
    add(1,0,0,0,32'h0,0,         0,1,0,32'h0);
    // Basic push A, B then drain.
    add(0,0,0,1,32'hBFC00000,0,  1,1,1,32'hBFC00000);
    add(0,0,0,1,32'hBFC00004,0,  1,1,2,32'hBFC00000);
    add(0,0,0,0,32'h0,1,         1,1,1,32'hBFC00004);
    add(0,0,0,0,32'h0,1,         0,1,0,32'h0);
    // Fill to DEPTH; fifth offer held until a pop frees a slot.
    add(0,0,0,1,32'h200,0,       1,1,1,32'h200);
    add(0,0,0,1,32'h204,0,       1,1,2,32'h200);
    add(0,0,0,1,32'h208,0,       1,1,3,32'h200);
    add(0,0,0,1,32'h20C,0,       1,0,4,32'h200);
    add(0,0,0,1,32'h210,0,       1,0,4,32'h200);
    add(0,0,0,1,32'h210,1,       1,1,3,32'h204);
    add(0,0,0,1,32'h210,0,       1,0,4,32'h204);
    add(0,0,0,0,32'h0,1,         1,1,3,32'h208);
    // Ten push+pop cycles across the pointer wrap: count stays 3.
    wrap_head[0] = 32'h20C;
    wrap_head[1] = 32'h210;
    for (int i = 0; i < 10; i++) begin
      add(0,0,0,1,32'h300 + 32'(4*i),1, 1,1,3,
          (i < 2) ? wrap_head[i] : 32'h300 + 32'(4*(i-2)));
    end
    add(0,0,0,0,32'h0,1,         1,1,2,32'h320);
    add(0,0,0,0,32'h0,1,         1,1,1,32'h324);
    add(0,0,0,0,32'h0,1,         0,1,0,32'h0);
    // Redirect with a full queue: only the delay slot survives.
    add(0,0,0,1,32'h100,0,       1,1,1,32'h100);
    add(0,0,0,1,32'h104,0,       1,1,2,32'h100);
    add(0,0,0,1,32'h108,0,       1,1,3,32'h100);
    add(0,0,0,1,32'h10C,0,       1,0,4,32'h100);
    add(0,1-1,1,1,32'h110,1,     1,1,1,32'h104);
    add(0,0,0,0,32'h0,1,         0,1,0,32'h0);
    // Redirect with three entries and an accepted-looking push that must be dropped.
    add(0,0,0,1,32'h100,0,       1,1,1,32'h100);
    add(0,0,0,1,32'h104,0,       1,1,2,32'h100);
    add(0,0,0,1,32'h108,0,       1,1,3,32'h100);
    add(0,0,1,1,32'h110,1,       1,1,1,32'h104);
    add(0,0,0,0,32'h0,1,         0,1,0,32'h0);
    // Single entry redirect: with push keeps it, without push empties.
    add(0,0,0,1,32'h100,0,       1,1,1,32'h100);
    add(0,0,1,1,32'h104,1,       1,1,1,32'h104);
    add(0,0,1,0,32'h0,1,         0,1,0,32'h0);
    // Flush of a full queue with push and pop offered.
    add(0,0,0,1,32'h400,0,       1,1,1,32'h400);
    add(0,0,0,1,32'h404,0,       1,1,2,32'h400);
    add(0,0,0,1,32'h408,0,       1,1,3,32'h400);
    add(0,0,0,1,32'h40C,0,       1,0,4,32'h400);
    add(0,1,0,1,32'h410,1,       0,1,0,32'h0);
    add(0,0,0,1,32'h500,0,       1,1,1,32'h500);
    add(0,0,0,1,32'h504,0,       1,1,2,32'h500);
    add(0,1,1,0,32'h0,1,         0,1,0,32'h0);
    // Reset mid-operation.
    add(0,0,0,1,32'h600,0,       1,1,1,32'h600);
    add(0,0,0,1,32'h604,0,       1,1,2,32'h600);
    add(0,0,0,1,32'h608,0,       1,1,3,32'h600);
    add(1,0,0,1,32'h60C,1,       0,1,0,32'h0);
    add(0,0,0,1,32'h700,0,       1,1,1,32'h700);
    add(0,0,0,0,32'h0,1,         0,1,0,32'h0);

    drive(1,0,0,0,32'h0,0);
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].redirect, vecs[i].iv, vecs[i].pc, vecs[i].ord);
      @(posedge clk);
      #1;
      check_outputs(i, vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_count, vecs[i].e_pc);
    end

    // Hand sequence: one push then a bounded wait for the head to appear.
    drive(0,0,0,1,32'h800,0);
    @(posedge clk);
    #1;
    drive(0,0,0,0,32'h0,0);
    seen = out_valid;
    k = 0;
    while (!seen && k < 4) begin
      @(posedge clk);
      #1;
      seen = out_valid;
      k++;
    end
    chk("seq.wait_valid", 32'(seen), 32'h1);
    chk("seq.latency",    32'(k),    32'h0);
    chk("seq.out_pc",     out_pc,    32'h800);
    // Hold with out_ready low: head must not move.
    @(posedge clk);
    #1;
    chk("seq.hold_pc",    out_pc,    32'h800);
    chk("seq.hold_count", 32'(count), 32'h1);
    drive(0,0,0,0,32'h0,1);
    @(posedge clk);
    #1;
    chk("seq.drain_valid", 32'(out_valid), 32'h0);
    chk("seq.drain_pc",    out_pc,         32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_inst_queue.md
# decode_inst_queue

Parametrised instruction queue between Fetch and Decode. It replaces the single-entry stall buffer with a DEPTH-entry FIFO of {pc, inst, meta} records, using valid/ready handshakes on both sides. It adds branch-redirect handling that keeps exactly one delay-slot entry. Fetch pushes returned instructions; Decode pops one per cycle when not stalled. CTRL flush empties the queue.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- PC_W, 32, pc width
- INST_W, 32, instruction width
- META_W, 3, sideband bits per entry ({F_adel, delayslot flag, ce}); carried opaquely
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception/eret flush from CTRL; discards all entries
- redirect  in  1  taken branch/jump resolved in Decode; valid only together with a pop
- in_valid  in  1  Fetch offers an entry
- in_ready  out  1  queue accepts an entry
- in_pc  in  PC_W  fetched pc
- in_inst  in  INST_W  fetched instruction word
- in_meta  in  META_W  sideband
- out_valid  out  1  head entry valid
- out_ready  in  1  Decode consumes the head (stall deasserted)
- out_pc  out  PC_W  head pc
- out_inst  out  INST_W  head instruction
- out_meta  out  META_W  head sideband
- count  out  CNT_W  current occupancy

## Operation
- Storage: circular buffer with rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap) plus a count register.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). out_valid = (count != 0). Both derive from registered count only, with no combinational path from in_valid or out_ready.
- Outputs show the entry at rd_ptr. When out_valid=0, out_pc, out_inst and out_meta are driven to 0, so a bubble decodes as nop.
- Normal update:
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - count += push − pop.
  - Simultaneous push and pop at any non-full, non-empty level keeps count unchanged.
- Empty with push: no bypass. The entry appears on the outputs the next cycle.
- Full: in_ready=0. A pop that cycle frees a slot visible the next cycle.
- redirect (ignored unless pop=1). After the head (the branch) is popped:
  - If count ≥ 2, the entry at rd_ptr+1 is the delay slot. It is retained, count←1, wr_ptr←rd_ptr+2, and any push that cycle is dropped.
  - If count = 1 and push=1, the pushed entry is the delay slot and is retained, so count←1.
  - If count = 1 and push=0, the queue becomes empty (count←0) and Fetch supplies the delay slot next.
- flush: count←0 and rd_ptr←wr_ptr. Any push or pop that cycle is discarded, and flush overrides redirect.
- Priority: rst > flush > redirect > normal.

## Timing
- Reset values: count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1, out_pc/out_inst/out_meta=0. Memory contents are don't-care.
- Push-to-out_valid latency is 1 cycle. A pop advances the head in the next cycle.
- Throughput is 1 push and 1 pop per cycle sustained.
- flush or redirect asserted in cycle N takes effect in cycle N+1 outputs. in_ready=1 in N+1 after a flush.
- rst mid-operation behaves like flush plus pointer zeroing. No entry survives.
- count never exceeds DEPTH or underflows. Pointer wrap at DEPTH−1→0 is seamless.

## Test plan
- Reset, then push A (pc 0xBFC00000) and B (0xBFC00004) with out_ready=0 → count=2 and out_pc=0xBFC00000. Raise out_ready for 2 cycles → A then B presented, count=0, out_valid=0, outputs all zero.
- DEPTH=4: push 5 entries with out_ready=0 → in_ready falls after the 4th and the 5th is held by Fetch. Pop 1 → in_ready=1 next cycle and the 5th is accepted. Run 10 push+pop cycles across the pointer wrap → order preserved, count constant.
- Queue holds {BEQ@0x100, DS@0x104, T1@0x108, T2@0x10C}. Pop with redirect=1 → next cycle count=1 and out_pc=0x104. The push offered that cycle is dropped.
- Queue holds only BEQ@0x100. Pop+redirect with simultaneous push of 0x104 → count=1, out_pc=0x104. Same case without push → count=0.
- Full queue with flush=1, in_valid=1, out_ready=1 → next cycle count=0, out_valid=0, in_ready=1. Flush and redirect together → flush wins, count=0.
- Assert rst with 3 entries queued → all outputs at reset values next cycle. A push after deassertion appears at out_pc unchanged.
